rr_arbiter_encoder: RTL and testbench

- Parametrised N-way arbiter with a built-in binary encoder.
- Successor to the fixed-priority 4-bit arbiter/encoder pair.
- Adds a registered one-hot grant, a binary grant index, grant locking until acknowledge, and a selectable round-robin or fixed-priority mode.
- Sits between N request sources and a shared resource: a bus master port or a UART transmit slot on the icestick designs.

---
 rtl/rr_arbiter_encoder_if.sv | 31 +++
 rtl/rr_arbiter_encoder.sv | 110 +++++++++++
 tb/tb_rr_arbiter_encoder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_encoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : rr_arbiter_encoder_if
// Description : Request/grant bundle between N requesters and the
//               rr_arbiter_encoder. The master side drives the requests,
//               mode select and acknowledge. The slave side (the arbiter)
//               returns the registered grant.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface rr_arbiter_encoder_if #(
  parameter int N = 4,
  parameter int W = $clog2(N)
);
  logic [N-1:0] req;
  logic         fixed;
  logic         ack;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_idx;
  logic         gnt_valid;

  modport master (
    output req, fixed, ack,
    input  gnt, gnt_idx, gnt_valid
  );

  modport slave (
    input  req, fixed, ack,
    output gnt, gnt_idx, gnt_valid
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : rr_arbiter_encoder
// Description : N-way arbiter with a registered one-hot grant, a binary grant
//               index and grant locking until acknowledge. The arbiter runs
//               either round-robin or fixed priority, with the lowest index
//               winning in fixed-priority mode.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module rr_arbiter_encoder #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 resetn,
  rr_arbiter_encoder_if.slave  bus
);

  localparam logic [0:0]   ST_IDLE  = 1'b0;
  localparam logic [0:0]   ST_BUSY  = 1'b1;
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  logic [0:0]   r_state;
  logic [N-1:0] r_gnt;
  logic [W-1:0] r_gnt_idx;
  logic [W-1:0] r_ptr;

  logic         w_release;
  logic         w_arb_en;
  logic         w_any_req;
  logic [W-1:0] w_ptr_next;
  logic [W-1:0] w_ptr_eff;
  logic [W-1:0] w_fx_idx;
  logic [W-1:0] w_rr_idx;
  logic         w_rr_found;
  logic [W:0]   w_cand;
  logic [W-1:0] w_win_idx;
  logic [N-1:0] w_win_onehot;

  // A held grant is only released by ack. The holder's successor becomes the
  // round-robin start point in that same cycle, so the releaser drops to the
  // lowest priority at once.
  assign w_release  = (r_state == ST_BUSY) && bus.ack;
  assign w_arb_en   = (r_state == ST_IDLE) || w_release;
  assign w_any_req  = |bus.req;
  assign w_ptr_next = (r_gnt_idx == LAST_IDX) ? '0 : r_gnt_idx + W'(1);
  assign w_ptr_eff  = w_release ? w_ptr_next : r_ptr;

  // Fixed priority: scan downward so the lowest set index is the last one assigned.
  always_comb begin
    w_fx_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i]) w_fx_idx = W'(i);
    end
  end

  // Round-robin: find the first request at or above the pointer, wrapping modulo N.
  // The modulo is done explicitly so non-power-of-two N wraps correctly.
  always_comb begin
    w_rr_idx   = w_ptr_eff;
    w_rr_found = 1'b0;
    w_cand     = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, w_ptr_eff} + (W+1)'(k);
      if (w_cand >= (W+1)'(N)) w_cand = w_cand - (W+1)'(N);
      if (!w_rr_found && bus.req[w_cand[W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_cand[W-1:0];
      end
    end
  end

  assign w_win_idx = bus.fixed ? w_fx_idx : w_rr_idx;

  generate
    for (genvar i = 0; i < N; i++) begin : g_onehot
      assign w_win_onehot[i] = (w_win_idx == W'(i));
    end
  endgenerate

  // Grant register and priority pointer. While busy without ack, everything
  // holds regardless of the request or mode inputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_ptr     <= '0;
    end else begin
      if (w_release) r_ptr <= w_ptr_next;
      if (w_arb_en) begin
        if (w_any_req) begin
          r_state   <= ST_BUSY;
          r_gnt     <= w_win_onehot;
          r_gnt_idx <= w_win_idx;
        end else begin
          r_state   <= ST_IDLE;
          r_gnt     <= '0;
          r_gnt_idx <= '0;
        end
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt_valid = (r_state == ST_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_rr_arbiter_encoder
// Description : Directed self-checking bench for rr_arbiter_encoder, with a
//               4-way and a 5-way instance.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_rr_arbiter_encoder;

  logic clk;
  logic resetn;
  int   n_compared;
  int   n_mismatched;

  rr_arbiter_encoder_if #(.N(4), .W(2)) bus4 ();
  rr_arbiter_encoder_if #(.N(5), .W(3)) bus5 ();

  rr_arbiter_encoder #(.N(4), .W(2)) u_dut4 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus4)
  );

  rr_arbiter_encoder #(.N(5), .W(3)) u_dut5 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus5)
  );

  // 10 time-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic expect4(input string tag, input logic [3:0] gnt,
                         input logic [1:0] idx, input logic valid);
    check_value({tag, ".gnt"},   32'(bus4.gnt),       32'(gnt));
    check_value({tag, ".idx"},   32'(bus4.gnt_idx),   32'(idx));
    check_value({tag, ".valid"}, 32'(bus4.gnt_valid), 32'(valid));
  endtask

  task automatic expect5(input string tag, input logic [4:0] gnt,
                         input logic [2:0] idx, input logic valid);
    check_value({tag, ".gnt"},   32'(bus5.gnt),       32'(gnt));
    check_value({tag, ".idx"},   32'(bus5.gnt_idx),   32'(idx));
    check_value({tag, ".valid"}, 32'(bus5.gnt_valid), 32'(valid));
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    resetn       = 1'b0;
    bus4.req = '0; bus4.fixed = 1'b0; bus4.ack = 1'b0;
    bus5.req = '0; bus5.fixed = 1'b0; bus5.ack = 1'b0;

    // Reset state
    #3;
    expect4("rst4", 4'b0000, 2'd0, 1'b0);
    expect5("rst5", 5'b00000, 3'd0, 1'b0);
    step();
    resetn = 1'b1;

    // Asynchronous reset while a grant is held
    bus4.req = 4'b0100;
    step();
    expect4("pre_rst", 4'b0100, 2'd2, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    expect4("async_rst", 4'b0000, 2'd0, 1'b0);
    step();
    resetn   = 1'b1;
    bus4.req = 4'b0001;
    step();
    expect4("post_rst", 4'b0001, 2'd0, 1'b1);
    bus4.ack = 1'b1; bus4.req = 4'b0000;
    step();
    expect4("post_rst_idle", 4'b0000, 2'd0, 1'b0);

    // Fixed priority: requester 1 beats requester 3 on every grant
    bus4.fixed = 1'b1; bus4.req = 4'b1010; bus4.ack = 1'b0;
    step();
    expect4("fix_first", 4'b0010, 2'd1, 1'b1);
    bus4.ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect4($sformatf("fix_regrant%0d", i), 4'b0010, 2'd1, 1'b1);
    end
    bus4.req = 4'b0000;
    step();
    expect4("fix_idle", 4'b0000, 2'd0, 1'b0);

    // Round-robin fairness from a fresh pointer, no idle bubbles
    pulse_reset();
    bus4.fixed = 1'b0; bus4.req = 4'b1111; bus4.ack = 1'b1;
    step();
    expect4("rr0", 4'b0001, 2'd0, 1'b1);
    step();
    expect4("rr1", 4'b0010, 2'd1, 1'b1);
    step();
    expect4("rr2", 4'b0100, 2'd2, 1'b1);
    step();
    expect4("rr3", 4'b1000, 2'd3, 1'b1);
    step();
    expect4("rr4", 4'b0001, 2'd0, 1'b1);
    bus4.req = 4'b0000;
    step();
    expect4("rr_idle", 4'b0000, 2'd0, 1'b0);

    // Lock: the grant holds without ack despite request and mode changes
    // (pointer is now 1)
    bus4.req = 4'b0010; bus4.ack = 1'b0;
    step();
    expect4("lock_grant", 4'b0010, 2'd1, 1'b1);
    bus4.req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      bus4.fixed = i[0];
      step();
      expect4($sformatf("lock_hold%0d", i), 4'b0010, 2'd1, 1'b1);
    end
    bus4.fixed = 1'b0; bus4.ack = 1'b1;
    step();
    expect4("lock_next", 4'b0001, 2'd0, 1'b1);
    bus4.req = 4'b0000;
    step();
    expect4("lock_idle", 4'b0000, 2'd0, 1'b0);

    // Move the pointer to 3: grant 2, then release it to idle
    bus4.req = 4'b0100; bus4.ack = 1'b0;
    step();
    expect4("ptr_setup", 4'b0100, 2'd2, 1'b1);
    bus4.req = 4'b0000; bus4.ack = 1'b1;
    step();
    expect4("ptr_idle", 4'b0000, 2'd0, 1'b0);

    // Ack while idle is ignored and leaves the pointer at 3
    for (int i = 0; i < 3; i++) begin
      step();
      expect4($sformatf("idle_ack%0d", i), 4'b0000, 2'd0, 1'b0);
    end
    bus4.req = 4'b1111; bus4.ack = 1'b0;
    step();
    expect4("ptr_kept", 4'b1000, 2'd3, 1'b1);

    // A sole requester is granted again on every ack
    bus4.req = 4'b0100; bus4.ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect4($sformatf("sole%0d", i), 4'b0100, 2'd2, 1'b1);
    end
    bus4.req = 4'b0000;
    step();
    expect4("sole_idle", 4'b0000, 2'd0, 1'b0);
    bus4.ack = 1'b0;

    // N=5 wrap from index 4 back to index 0
    bus5.fixed = 1'b0; bus5.req = 5'b10000; bus5.ack = 1'b0;
    step();
    expect5("n5_hold4", 5'b10000, 3'd4, 1'b1);
    bus5.req = 5'b10001; bus5.ack = 1'b1;
    step();
    expect5("n5_wrap0", 5'b00001, 3'd0, 1'b1);
    step();
    expect5("n5_back4", 5'b10000, 3'd4, 1'b1);
    step();
    expect5("n5_wrap0b", 5'b00001, 3'd0, 1'b1);
    bus5.req = 5'b00000;
    step();
    expect5("n5_idle", 5'b00000, 3'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
